// File: rtl/sdp_sram_be_if.sv
// sdp_sram_be_if: write/read bus bundle for the sdp_sram_be simple dual-port SRAM.
// The master side issues write and read requests.
// The slave side (the memory) returns read data, the valid strobe, the collision flag and busy.
interface sdp_sram_be_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    localparam int NB = DATA_W / 8;

    logic              we;
    logic [NB-1:0]     wbe;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              coll;
    logic              busy;

    modport master (
        output we, wbe, waddr, wdata, re, raddr,
        input  rdata, rvalid, coll, busy
    );

    modport slave (
        input  we, wbe, waddr, wdata, re, raddr,
        output rdata, rvalid, coll, busy
    );
endinterface

// File: rtl/sdp_sram_be.sv
// sdp_sram_be: simple dual-port SRAM with per-byte write enables.
// - Reads are registered, with a read latency of 1 or 2 cycles (RD_LAT).
// - rvalid is a one-cycle strobe for each accepted read.
// - A same-address read/write collision is resolved by WR_FIRST and flagged on coll.
// - The memory array is never reset; only the read pipeline is.
// Optional macro SDP_SRAM_INIT_CLEAR_EN enables a post-reset sweep that zeroes every word.
// While that sweep runs, busy is high and the external ports are ignored.
module sdp_sram_be #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int NB       = DATA_W / 8,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    sdp_sram_be_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Elaboration-time parameter sanity checks
    initial begin
        if (RD_LAT != 1 && RD_LAT != 2) begin
            $fatal(1, "sdp_sram_be: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % 8) != 0 || NB != DATA_W / 8) begin
            $fatal(1, "sdp_sram_be: DATA_W must be a multiple of 8 and NB must equal DATA_W/8");
        end
    end

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    logic              busy_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              coll_s;
    logic [DATA_W-1:0] old_word_s;
    logic [DATA_W-1:0] merged_word_s;
    logic [DATA_W-1:0] rd_word_s;

    logic              mem_we_s;
    logic [NB-1:0]     mem_be_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    logic              v1_r;
    logic              c1_r;
    logic [DATA_W-1:0] d1_r;

`ifdef SDP_SRAM_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              busy_r;

    // Init-clear sequencer: reset arms a full sweep, READY holds until the next reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    busy_r     <= 1'b1;
                    clr_addr_r <= clr_addr_r + ADDR_W'(1);
                    if (clr_addr_r == {ADDR_W{1'b1}}) begin
                        state_r <= ST_READY;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_READY: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    // IDLE or an illegal encoding: restart the sweep from the bottom
                    state_r    <= ST_CLEAR;
                    clr_addr_r <= {ADDR_W{1'b0}};
                    busy_r     <= 1'b1;
                end
            endcase
        end
    end

    assign busy_s = busy_r;
`else
    assign busy_s = 1'b0;
`endif

    assign bus.busy = busy_s;

    // Qualify external requests, pick the collision read word, and flag collisions
    always_comb begin
        wr_en_s       = bus.we && !busy_s;
        rd_en_s       = bus.re && !busy_s;
        old_word_s    = mem_r[bus.raddr];
        merged_word_s = old_word_s;
        for (int i = 0; i < NB; i++) begin
            if (bus.wbe[i]) begin
                merged_word_s[8*i +: 8] = bus.wdata[8*i +: 8];
            end else begin
                merged_word_s[8*i +: 8] = old_word_s[8*i +: 8];
            end
        end
        coll_s = rd_en_s && wr_en_s && (bus.raddr == bus.waddr) && (bus.wbe != {NB{1'b0}});
        if (coll_s && (WR_FIRST != 0)) begin
            rd_word_s = merged_word_s;
        end else begin
            rd_word_s = old_word_s;
        end
    end

    // Select the array write source; the init sweep overrides the external port
    always_comb begin
        mem_we_s    = wr_en_s;
        mem_be_s    = bus.wbe;
        mem_addr_s  = bus.waddr;
        mem_wdata_s = bus.wdata;
`ifdef SDP_SRAM_INIT_CLEAR_EN
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_be_s    = {NB{1'b1}};
            mem_addr_s  = clr_addr_r;
            mem_wdata_s = {DATA_W{1'b0}};
        end else begin
            mem_we_s    = wr_en_s;
        end
`endif
    end

    // Byte-masked array write; deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be_s[i]) begin
                    mem_r[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // First read stage: valid and coll pulse per read; data holds across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            c1_r <= 1'b0;
            d1_r <= {DATA_W{1'b0}};
        end else begin
            v1_r <= rd_en_s;
            c1_r <= coll_s;
            if (rd_en_s) begin
                d1_r <= rd_word_s;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2_r;
            logic              c2_r;
            logic [DATA_W-1:0] d2_r;

            // Second output stage: valid, coll and data advance together
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_r <= 1'b0;
                    c2_r <= 1'b0;
                    d2_r <= {DATA_W{1'b0}};
                end else begin
                    v2_r <= v1_r;
                    c2_r <= c1_r;
                    if (v1_r) begin
                        d2_r <= d1_r;
                    end
                end
            end

            assign bus.rvalid = v2_r;
            assign bus.coll   = c2_r;
            assign bus.rdata  = d2_r;
        end else begin : g_lat1
            assign bus.rvalid = v1_r;
            assign bus.coll   = c1_r;
            assign bus.rdata  = d1_r;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_sram_be.sv
// tb_sdp_sram_be: directed self-checking bench for sdp_sram_be.
// Three instances share one stimulus stream:
//   a: RD_LAT=1, WR_FIRST=0
//   b: RD_LAT=1, WR_FIRST=1
//   c: RD_LAT=2, WR_FIRST=0
// Build with SDP_SRAM_INIT_CLEAR_EN defined to exercise the init-clear sweep instead.
module tb_sdp_sram_be;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [7:0]  wbe;
    logic [3:0]  waddr;
    logic [63:0] wdata;
    logic        re;
    logic [3:0]  raddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_sram_be_if #(.ADDR_W(4), .DATA_W(64)) ifa ();
    sdp_sram_be_if #(.ADDR_W(4), .DATA_W(64)) ifb ();
    sdp_sram_be_if #(.ADDR_W(4), .DATA_W(64)) ifc ();

    assign ifa.we = we;  assign ifa.wbe = wbe;  assign ifa.waddr = waddr;
    assign ifa.wdata = wdata;  assign ifa.re = re;  assign ifa.raddr = raddr;
    assign ifb.we = we;  assign ifb.wbe = wbe;  assign ifb.waddr = waddr;
    assign ifb.wdata = wdata;  assign ifb.re = re;  assign ifb.raddr = raddr;
    assign ifc.we = we;  assign ifc.wbe = wbe;  assign ifc.waddr = waddr;
    assign ifc.wdata = wdata;  assign ifc.re = re;  assign ifc.raddr = raddr;

    sdp_sram_be #(.ADDR_W(4), .DATA_W(64), .RD_LAT(1), .WR_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    sdp_sram_be #(.ADDR_W(4), .DATA_W(64), .RD_LAT(1), .WR_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    sdp_sram_be #(.ADDR_W(4), .DATA_W(64), .RD_LAT(2), .WR_FIRST(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wbe = 8'h00; waddr = 4'd0; wdata = 64'd0; re = 1'b0; raddr = 4'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ifa.rdata !== 64'd0 || ifa.rvalid !== 1'b0 || ifa.coll !== 1'b0) begin
            errors++; $display("FAIL reset_a got rdata=%h rvalid=%b coll=%b exp 0/0/0", ifa.rdata, ifa.rvalid, ifa.coll); end
        checks++; if (ifc.rdata !== 64'd0 || ifc.rvalid !== 1'b0 || ifc.coll !== 1'b0) begin
            errors++; $display("FAIL reset_c got rdata=%h rvalid=%b coll=%b exp 0/0/0", ifc.rdata, ifc.rvalid, ifc.coll); end
        checks++; if (ifa.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", ifa.busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        we = 1'b1; wbe = 8'hFF; waddr = 4'd5; wdata = 64'h1122334455667788;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd5;
        checks++; if (ifa.rvalid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_early_valid got %b exp 0", ifa.rvalid); end
        tick();
        checks++; if (ifa.rvalid !== 1'b1 || ifa.rdata !== 64'h1122334455667788 || ifa.coll !== 1'b0) begin
            errors++; $display("FAIL wr_rd_a got v=%b d=%h c=%b exp 1/1122334455667788/0", ifa.rvalid, ifa.rdata, ifa.coll); end
        checks++; if (ifc.rvalid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_c_lat got %b exp 0", ifc.rvalid); end
        re = 1'b0;
        tick();
        checks++; if (ifa.rvalid !== 1'b0 || ifa.rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_rd_a_hold got v=%b d=%h exp 0/1122334455667788", ifa.rvalid, ifa.rdata); end
        checks++; if (ifc.rvalid !== 1'b1 || ifc.rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL wr_rd_c got v=%b d=%h exp 1/1122334455667788", ifc.rvalid, ifc.rdata); end
        tick();
        checks++; if (ifc.rvalid !== 1'b0) begin
            errors++; $display("FAIL wr_rd_c_pulse got %b exp 0", ifc.rvalid); end
    endtask

    task automatic test_byte_enable();
        we = 1'b1; wbe = 8'h0F; waddr = 4'd5; wdata = 64'hAAAAAAAAAAAAAAAA;
        tick();
        wbe = 8'h00; wdata = 64'h0;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd5;
        tick();
        re = 1'b0;
        checks++; if (ifa.rdata !== 64'h11223344AAAAAAAA) begin
            errors++; $display("FAIL byte_en got %h exp 11223344aaaaaaaa", ifa.rdata); end
        tick();
    endtask

    task automatic test_collision();
        we = 1'b1; wbe = 8'hFF; waddr = 4'd7; wdata = 64'h0;
        tick();
        wbe = 8'h01; wdata = 64'hFFFFFFFFFFFFFFFF; re = 1'b1; raddr = 4'd7;
        tick();
        checks++; if (ifa.rdata !== 64'h0 || ifa.coll !== 1'b1 || ifa.rvalid !== 1'b1) begin
            errors++; $display("FAIL coll_old got d=%h c=%b v=%b exp 0/1/1", ifa.rdata, ifa.coll, ifa.rvalid); end
        checks++; if (ifb.rdata !== 64'h00000000000000FF || ifb.coll !== 1'b1) begin
            errors++; $display("FAIL coll_new got d=%h c=%b exp ff/1", ifb.rdata, ifb.coll); end
        // Different addresses: no collision, old contents of addr 5
        wbe = 8'hFF; wdata = 64'h0; waddr = 4'd7; raddr = 4'd5;
        tick();
        checks++; if (ifa.coll !== 1'b0 || ifa.rdata !== 64'h11223344AAAAAAAA) begin
            errors++; $display("FAIL coll_diff got d=%h c=%b exp 11223344aaaaaaaa/0", ifa.rdata, ifa.coll); end
        checks++; if (ifc.coll !== 1'b1 || ifc.rdata !== 64'h0) begin
            errors++; $display("FAIL coll_c_lat2 got d=%h c=%b exp 0/1", ifc.rdata, ifc.coll); end
        // Same address with wbe=0 is not a collision
        wbe = 8'h00; wdata = 64'h1234; raddr = 4'd7;
        tick();
        checks++; if (ifb.coll !== 1'b0 || ifb.rdata !== 64'h0) begin
            errors++; $display("FAIL coll_wbe0 got d=%h c=%b exp 0/0", ifb.rdata, ifb.coll); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            we = 1'b1; wbe = 8'hFF; waddr = 4'(k); wdata = 64'(100 + k);
            tick();
        end
        we = 1'b0;
        for (int k = 0; k < 19; k++) begin
            re = (k < 16); raddr = 4'(k);
            tick();
            checks++; if (ifc.rvalid !== ((k >= 1) && (k <= 16))) begin
                errors++; $display("FAIL b2b_c_valid cyc %0d got %b", k, ifc.rvalid); end
            if (k >= 1 && k <= 16) begin
                checks++; if (ifc.rdata !== 64'(100 + k - 1)) begin
                    errors++; $display("FAIL b2b_c_data cyc %0d got %0d exp %0d", k, ifc.rdata, 100 + k - 1); end
            end
            if (k < 16) begin
                checks++; if (ifa.rvalid !== 1'b1 || ifa.rdata !== 64'(100 + k)) begin
                    errors++; $display("FAIL b2b_a cyc %0d got v=%b d=%0d exp 1/%0d", k, ifa.rvalid, ifa.rdata, 100 + k); end
            end
        end
        checks++; if (ifc.rdata !== 64'd115) begin
            errors++; $display("FAIL b2b_c_hold got %0d exp 115", ifc.rdata); end
    endtask

    task automatic test_mid_reset();
        re = 1'b1; raddr = 4'd3;
        tick();
        checks++; if (ifa.rvalid !== 1'b1 || ifa.rdata !== 64'd103) begin
            errors++; $display("FAIL mr_a_pre got v=%b d=%0d exp 1/103", ifa.rvalid, ifa.rdata); end
        re = 1'b0; rst_n = 1'b0;
        we = 1'b1; wbe = 8'hFF; waddr = 4'd9; wdata = 64'h5555555555555555;
        tick();
        checks++; if (ifc.rvalid !== 1'b0 || ifc.rdata !== 64'd0) begin
            errors++; $display("FAIL mr_c_flush got v=%b d=%h exp 0/0", ifc.rvalid, ifc.rdata); end
        checks++; if (ifa.rdata !== 64'd0) begin
            errors++; $display("FAIL mr_a_clear got %h exp 0", ifa.rdata); end
        we = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ifc.rvalid !== 1'b0 || ifa.rvalid !== 1'b0) begin
                errors++; $display("FAIL mr_ghost cyc %0d got a=%b c=%b exp 0/0", k, ifa.rvalid, ifc.rvalid); end
        end
        re = 1'b1; raddr = 4'd3;
        tick();
        checks++; if (ifa.rdata !== 64'd103) begin
            errors++; $display("FAIL mr_keep got %0d exp 103", ifa.rdata); end
        raddr = 4'd9;
        tick();
        checks++; if (ifa.rdata !== 64'h5555555555555555) begin
            errors++; $display("FAIL mr_wr_at_rst got %h exp 5555555555555555", ifa.rdata); end
        re = 1'b0;
        tick();
    endtask

    task automatic test_init_clear();
        int busy_cnt;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ifa.busy !== 1'b1) begin
            errors++; $display("FAIL ic_busy_rst got %b exp 1", ifa.busy); end
        rst_n = 1'b1;
        we = 1'b1; wbe = 8'hFF; waddr = 4'd2; wdata = 64'hFFFFFFFFFFFFFFFF;
        re = 1'b1; raddr = 4'd2;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            we = 1'b0; re = 1'b0;
            checks++; if (ifa.rvalid !== 1'b0) begin
                errors++; $display("FAIL ic_rvalid_busy cyc %0d got 1 exp 0", k); end
            if (ifa.busy === 1'b1) busy_cnt++;
            else break;
        end
        checks++; if (busy_cnt != 16) begin
            errors++; $display("FAIL ic_busy_len got %0d exp 16", busy_cnt); end
        for (int k = 0; k < 16; k++) begin
            re = 1'b1; raddr = 4'(k);
            tick();
            checks++; if (ifa.rvalid !== 1'b1 || ifa.rdata !== 64'd0) begin
                errors++; $display("FAIL ic_zero addr %0d got v=%b d=%h exp 1/0", k, ifa.rvalid, ifa.rdata); end
        end
        re = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
`ifdef SDP_SRAM_INIT_CLEAR_EN
        test_init_clear();
`else
        test_reset();
        test_write_read();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_mid_reset();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
